// File: rtl/flash_cmd_pkg.sv
// Shared types and opcode helpers for the flash-slave command sequencer.
package flash_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        DATA,
        PEND
    } cmd_state_t;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;

    function automatic logic op_has_addr(input logic [7:0] opcode);
        return (opcode == OP_READ) || (opcode == OP_PROG);
    endfunction

    function automatic logic op_known(input logic [7:0] opcode);
        return op_has_addr(opcode) || (opcode == OP_WREN) || (opcode == OP_RDSR);
    endfunction

endpackage

// File: rtl/flash_cmd_sequencer_packer.sv
// Edge-detects deserializer nibble pulses and pairs them (high nibble first) into bytes.
module nibble_byte_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nib_pulse,
    input  logic [3:0] nib_data,
    input  logic       accept,
    output logic       byte_strobe,
    output logic [7:0] byte_val
);

    logic       pulse_q;
    logic       phase;
    logic [3:0] hi_nib;
    logic       nib_event;

    assign nib_event   = nib_pulse & ~pulse_q;
    assign byte_strobe = nib_event & accept & phase;
    assign byte_val    = {hi_nib, nib_data};

    // Dropping accept discards a half-collected byte so the next byte starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            phase   <= 1'b0;
            hi_nib  <= '0;
        end else begin
            pulse_q <= nib_pulse;
            if (!accept) begin
                phase <= 1'b0;
            end else if (nib_event) begin
                if (!phase) hi_nib <= nib_data;
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Collects opcode/address/data bytes from the SPI deserializer and presents them on a valid/ack handshake.
module flash_cmd_sequencer
    import flash_cmd_pkg::*;
#(
    parameter int unsigned ADDR_BYTES = 3
) (
    input  logic                    sck,
    input  logic                    ss,
    input  logic                    en,
    input  logic                    nib_pulse,
    input  logic [3:0]              nib_data,
    input  logic                    cmd_ack,
    output logic                    sipo_ready,
    output logic                    sipo_done,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_opcode,
    output logic [8*ADDR_BYTES-1:0] cmd_addr,
    output logic [7:0]              cmd_data,
    output logic                    cmd_err
);

    localparam int unsigned ADDR_W = 8 * ADDR_BYTES;

    cmd_state_t state;
    cmd_state_t state_n;
    logic [3:0] byte_cnt;
    logic       accept;
    logic       byte_strobe;
    logic [7:0] byte_val;
    logic       bad_op;
    logic       addr_last;

    assign accept    = en && ((state == OPCODE) || (state == ADDR) || (state == DATA));
    assign bad_op    = (state == OPCODE) && byte_strobe && !op_known(byte_val);
    assign addr_last = (byte_cnt == 4'(ADDR_BYTES - 1));

    nibble_byte_packer u_packer (
        .clk        (sck),
        .rst_n      (ss),
        .nib_pulse  (nib_pulse),
        .nib_data   (nib_data),
        .accept     (accept),
        .byte_strobe(byte_strobe),
        .byte_val   (byte_val)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (en) state_n = OPCODE;
            OPCODE: if (byte_strobe && op_known(byte_val))
                        state_n = op_has_addr(byte_val) ? ADDR : PEND;
            ADDR:   if (byte_strobe && addr_last)
                        state_n = (cmd_opcode == OP_PROG) ? DATA : PEND;
            DATA:   if (byte_strobe) state_n = PEND;
            PEND:   if (cmd_ack) state_n = OPCODE;
            default: state_n = IDLE;
        endcase
        if (!en) state_n = IDLE;
    end

    always_ff @(posedge sck or negedge ss) begin
        if (!ss) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            sipo_ready <= 1'b0;
            sipo_done  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_opcode <= '0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
        end else begin
            state      <= state_n;
            sipo_ready <= (state_n != IDLE);
            sipo_done  <= (state_n == PEND);
            cmd_valid  <= (state_n == PEND);
            cmd_err    <= bad_op;

            if ((state_n != state) || bad_op) byte_cnt <= '0;
            else if (byte_strobe)             byte_cnt <= byte_cnt + 4'd1;

            // Abort and acknowledge both leave the fields zeroed for the next frame.
            if (!en || ((state == PEND) && cmd_ack)) begin
                cmd_opcode <= '0;
                cmd_addr   <= '0;
                cmd_data   <= '0;
            end else if (byte_strobe) begin
                case (state)
                    OPCODE:  if (op_known(byte_val)) cmd_opcode <= byte_val;
                    ADDR:    cmd_addr <= (cmd_addr << 8) | ADDR_W'(byte_val);
                    DATA:    cmd_data <= byte_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed, table-driven bench for flash_cmd_sequencer with ADDR_BYTES=3.
module tb_flash_cmd_sequencer;

    logic        sck = 1'b0;
    logic        ss;
    logic        en;
    logic        nib_pulse;
    logic [3:0]  nib_data;
    logic        cmd_ack;
    logic        sipo_ready;
    logic        sipo_done;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        cmd_err;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic        en;
        logic        p;
        logic [3:0]  n;
        logic        ack;
        logic        rdy;
        logic        pend;
        logic        err;
        logic [7:0]  op;
        logic [23:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[$];

    flash_cmd_sequencer #(.ADDR_BYTES(3)) dut (
        .sck       (sck),
        .ss        (ss),
        .en        (en),
        .nib_pulse (nib_pulse),
        .nib_data  (nib_data),
        .cmd_ack   (cmd_ack),
        .sipo_ready(sipo_ready),
        .sipo_done (sipo_done),
        .cmd_valid (cmd_valid),
        .cmd_opcode(cmd_opcode),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_err   (cmd_err)
    );

    always #5 sck = ~sck;

    function automatic void push(input logic e, input logic p, input logic [3:0] n, input logic a,
                                 input logic rdy, input logic pend, input logic err,
                                 input logic [7:0] op, input logic [23:0] addr, input logic [7:0] data);
        vec_t v;
        v.en = e; v.p = p; v.n = n; v.ack = a;
        v.rdy = rdy; v.pend = pend; v.err = err;
        v.op = op; v.addr = addr; v.data = data;
        vecs.push_back(v);
    endfunction

    // One nibble: pulse cycle then idle cycle, same expected outputs after each.
    function automatic void nib(input logic [3:0] n, input logic pend, input logic [7:0] op,
                                input logic [23:0] addr, input logic [7:0] data);
        push(1'b1, 1'b1, n, 1'b0, 1'b1, pend, 1'b0, op, addr, data);
        push(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, pend, 1'b0, op, addr, data);
    endfunction

    task automatic check(input string name, input logic rdy, input logic pend, input logic err,
                         input logic [7:0] op, input logic [23:0] addr, input logic [7:0] data);
        logic [43:0] got;
        logic [43:0] exp;
        got = {sipo_ready, sipo_done, cmd_valid, cmd_err, cmd_opcode, cmd_addr, cmd_data};
        exp = {rdy, pend, pend, err, op, addr, data};
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got rdy/done/valid/err/op/addr/data=%h required %h", name, got, exp);
    endtask

    task automatic step(input logic e, input logic p, input logic [3:0] n, input logic a);
        @(negedge sck);
        en = e; nib_pulse = p; nib_data = n; cmd_ack = a;
        @(posedge sck);
        #1;
    endtask

    task automatic hnib(input logic [3:0] n);
        step(1'b1, 1'b1, n, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        ss = 1'b0; en = 1'b0; nib_pulse = 1'b0; nib_data = '0; cmd_ack = 1'b0;

        // Enable, then WREN with ack tied high.
        push(1, 0, 4'h0, 0, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        push(1, 1, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        push(1, 0, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        push(1, 1, 4'h6, 1, 1, 1, 0, 8'h06, 24'h0, 8'h00);
        push(1, 0, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        push(1, 0, 4'h0, 0, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        // READ 0x123456, valid held until ack.
        nib(4'h0, 0, 8'h00, 24'h0, 8'h00);
        nib(4'h3, 0, 8'h03, 24'h0, 8'h00);
        nib(4'h1, 0, 8'h03, 24'h0, 8'h00);
        nib(4'h2, 0, 8'h03, 24'h12, 8'h00);
        nib(4'h3, 0, 8'h03, 24'h12, 8'h00);
        nib(4'h4, 0, 8'h03, 24'h1234, 8'h00);
        nib(4'h5, 0, 8'h03, 24'h1234, 8'h00);
        push(1, 1, 4'h6, 0, 1, 1, 0, 8'h03, 24'h123456, 8'h00);
        for (int i = 0; i < 4; i++) push(1, 0, 4'h0, 0, 1, 1, 0, 8'h03, 24'h123456, 8'h00);
        push(1, 0, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        // PROG 0xABCDEF / 0x5A, then extra nibbles while pending.
        nib(4'h0, 0, 8'h00, 24'h0, 8'h00);
        nib(4'h2, 0, 8'h02, 24'h0, 8'h00);
        nib(4'hA, 0, 8'h02, 24'h0, 8'h00);
        nib(4'hB, 0, 8'h02, 24'hAB, 8'h00);
        nib(4'hC, 0, 8'h02, 24'hAB, 8'h00);
        nib(4'hD, 0, 8'h02, 24'hABCD, 8'h00);
        nib(4'hE, 0, 8'h02, 24'hABCD, 8'h00);
        nib(4'hF, 0, 8'h02, 24'hABCDEF, 8'h00);
        nib(4'h5, 0, 8'h02, 24'hABCDEF, 8'h00);
        nib(4'hA, 1, 8'h02, 24'hABCDEF, 8'h5A);
        nib(4'h3, 1, 8'h02, 24'hABCDEF, 8'h5A);
        nib(4'h7, 1, 8'h02, 24'hABCDEF, 8'h5A);
        push(1, 0, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        // Unknown opcode 0xFF, then RDSR.
        nib(4'hF, 0, 8'h00, 24'h0, 8'h00);
        push(1, 1, 4'hF, 0, 1, 0, 1, 8'h00, 24'h0, 8'h00);
        push(1, 0, 4'h0, 0, 1, 0, 0, 8'h00, 24'h0, 8'h00);
        nib(4'h0, 0, 8'h00, 24'h0, 8'h00);
        push(1, 1, 4'h5, 0, 1, 1, 0, 8'h05, 24'h0, 8'h00);
        push(1, 0, 4'h0, 1, 1, 0, 0, 8'h00, 24'h0, 8'h00);

        #3;
        check("reset_async", 0, 0, 0, 8'h00, 24'h0, 8'h00);
        @(negedge sck);
        ss = 1'b1;
        step(0, 0, 4'h0, 0);
        check("idle_en_low", 0, 0, 0, 8'h00, 24'h0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].p, vecs[i].n, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].pend, vecs[i].err,
                  vecs[i].op, vecs[i].addr, vecs[i].data);
        end

        // Held pulse counts once: a double count would pair 0,0 into a bad opcode.
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 4'h0, 0);
            check($sformatf("held%0d", i), 1, 0, 0, 8'h00, 24'h0, 8'h00);
        end
        step(1, 0, 4'h0, 0);
        step(1, 1, 4'h6, 0);
        check("held_wren", 1, 1, 0, 8'h06, 24'h0, 8'h00);
        step(1, 0, 4'h0, 1);
        check("held_ack", 1, 0, 0, 8'h00, 24'h0, 8'h00);

        // en low mid-address, then en low together with ack in PEND.
        hnib(4'h0); hnib(4'h3); hnib(4'h1);
        check("abort_pre", 1, 0, 0, 8'h03, 24'h0, 8'h00);
        step(0, 0, 4'h0, 0);
        check("abort_idle", 0, 0, 0, 8'h00, 24'h0, 8'h00);
        step(1, 0, 4'h0, 0);
        check("abort_reen", 1, 0, 0, 8'h00, 24'h0, 8'h00);
        hnib(4'h0);
        step(1, 1, 4'h6, 0);
        check("abort_wren", 1, 1, 0, 8'h06, 24'h0, 8'h00);
        step(0, 0, 4'h0, 1);
        check("ack_and_abort", 0, 0, 0, 8'h00, 24'h0, 8'h00);
        step(1, 0, 4'h0, 0);
        check("after_abort_ack", 1, 0, 0, 8'h00, 24'h0, 8'h00);

        // ss low after three address nibbles.
        hnib(4'h0); hnib(4'h3); hnib(4'h1); hnib(4'h2); hnib(4'h3);
        check("ss_pre", 1, 0, 0, 8'h03, 24'h12, 8'h00);
        @(negedge sck);
        ss = 1'b0;
        #1;
        check("ss_async", 0, 0, 0, 8'h00, 24'h0, 8'h00);
        @(posedge sck);
        #1;
        check("ss_held", 0, 0, 0, 8'h00, 24'h0, 8'h00);
        @(negedge sck);
        ss = 1'b1;
        en = 1'b1;
        @(posedge sck);
        #1;
        check("ss_restart", 1, 0, 0, 8'h00, 24'h0, 8'h00);
        hnib(4'h0);
        step(1, 1, 4'h6, 0);
        check("ss_wren", 1, 1, 0, 8'h06, 24'h0, 8'h00);
        step(1, 0, 4'h0, 1);
        check("ss_wren_ack", 1, 0, 0, 8'h00, 24'h0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
